hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage RV32I core. Takes the decoded control bits for the ID-stage

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the ID/EX pipeline datapath and the hazard sequencer.
// master = pipeline side (drives decoded ID bits and stall/redirect), slave = sequencer.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_id_insn_vld;
    logic [4:0]       i_id_rs1_addr;
    logic [4:0]       i_id_rs2_addr;
    logic             i_id_use_rs1;
    logic             i_id_use_rs2;
    logic [4:0]       i_id_rd_addr;
    logic             i_id_rd_wren;
    logic             i_id_mem_rden;
    logic             i_ex_redirect;
    logic             i_mem_stall;
    logic             i_cnt_clr;
    logic             o_pc_en;
    logic             o_if_id_en;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_pipe_en;
    logic [1:0]       o_fwd_a_sel;
    logic [1:0]       o_fwd_b_sel;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_insn_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_use_rs1, i_id_use_rs2,
               i_id_rd_addr, i_id_rd_wren, i_id_mem_rden, i_ex_redirect, i_mem_stall, i_cnt_clr,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_insn_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_use_rs1, i_id_use_rs2,
               i_id_rd_addr, i_id_rd_wren, i_id_mem_rden, i_ex_redirect, i_mem_stall, i_cnt_clr,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage RV32I hazard sequencer: stall/flush enables, EX forwarding selects, perf counters.
// Zero-latency combinational decisions; i_mem_stall freezes everything (enables low, state held).
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic [4:0] rd;
        logic       wren;
        logic       rden;
    } stage_t;

    typedef struct packed {
        stage_t     st;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } ex_stage_t;

    ex_stage_t        r_ex;
    stage_t           r_mem;
    stage_t           r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic      w_load_use;
    logic      w_pc_en;
    logic      w_if_id_en;
    logic      w_if_id_flush;
    logic      w_id_ex_flush;
    logic      w_pipe_en;
    logic      w_inc_stall;
    logic      w_inc_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    ex_stage_t w_ex_nxt;

    always_comb begin
        w_load_use = r_ex.st.rden && (r_ex.st.rd != 5'd0) && bus.i_id_insn_vld &&
                     ((bus.i_id_use_rs1 && (bus.i_id_rs1_addr == r_ex.st.rd)) ||
                      (bus.i_id_use_rs2 && (bus.i_id_rs2_addr == r_ex.st.rd)));
    end

    // A redirect kills the ID instruction, so its load-use hazard is moot.
    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_pipe_en     = 1'b1;
        w_inc_stall   = 1'b0;
        w_inc_flush   = 1'b0;
        if (bus.i_mem_stall) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_pipe_en  = 1'b0;
        end else if (bus.i_ex_redirect) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_inc_flush   = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
            w_inc_stall   = 1'b1;
        end
    end

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_mem.wren && (r_mem.rd != 5'd0) && r_ex.use1 && (r_mem.rd == r_ex.rs1))
            w_fwd_a = 2'b01;
        else if (r_wb.wren && (r_wb.rd != 5'd0) && r_ex.use1 && (r_wb.rd == r_ex.rs1))
            w_fwd_a = 2'b10;
        if (r_mem.wren && (r_mem.rd != 5'd0) && r_ex.use2 && (r_mem.rd == r_ex.rs2))
            w_fwd_b = 2'b01;
        else if (r_wb.wren && (r_wb.rd != 5'd0) && r_ex.use2 && (r_wb.rd == r_ex.rs2))
            w_fwd_b = 2'b10;
    end

    always_comb begin
        w_ex_nxt = '0;
        if (!w_id_ex_flush && bus.i_id_insn_vld) begin
            w_ex_nxt.st.rd   = bus.i_id_rd_addr;
            w_ex_nxt.st.wren = bus.i_id_rd_wren;
            w_ex_nxt.st.rden = bus.i_id_mem_rden;
            w_ex_nxt.rs1     = bus.i_id_rs1_addr;
            w_ex_nxt.rs2     = bus.i_id_rs2_addr;
            w_ex_nxt.use1    = bus.i_id_use_rs1;
            w_ex_nxt.use2    = bus.i_id_use_rs2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!bus.i_mem_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex.st;
            r_ex  <= w_ex_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_inc_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_inc_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.o_pc_en       = w_pc_en;
    assign bus.o_if_id_en    = w_if_id_en;
    assign bus.o_if_id_flush = w_if_id_flush;
    assign bus.o_id_ex_flush = w_id_ex_flush;
    assign bus.o_pipe_en     = w_pipe_en;
    assign bus.o_fwd_a_sel   = w_fwd_a;
    assign bus.o_fwd_b_sel   = w_fwd_b;
    assign bus.o_stall_cnt   = r_stall_cnt;
    assign bus.o_flush_cnt   = r_flush_cnt;
endmodule
